// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fir_tap_sequencer: drives a shared MAC through one FIR output per sample,
// then rounds, shifts and saturates the accumulator.            Revision 1.0
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter int NTAPS   = 10,
  parameter int NBANDS  = 4,
  parameter int MAC_LAT = 1,
  parameter int SHIFT   = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_valid_i,
  input  logic [7:0]  band_i,
  output logic        win_hold_o,
  output logic        busy_o,
  output logic [7:0]  coef_addr_o,
  input  logic [15:0] coef_data_i,
  output logic        mac_clr_o,
  output logic        mac_en_o,
  output logic [15:0] tap_o,
  output logic [7:0]  tapnum_o,
  input  logic [32:0] mac_result_i,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        overrun_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RUN   = 3'd2,
    S_WAIT  = 3'd3,
    S_SCALE = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam logic [7:0]  c_NTAPS     = 8'(NTAPS);
  localparam logic [7:0]  c_LAST_TAP  = 8'(NTAPS - 1);
  localparam logic [7:0]  c_LAST_WAIT = 8'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam logic [7:0]  c_NBANDS    = 8'(NBANDS);
  localparam logic [33:0] c_ROUND_U   = (34'd1 << SHIFT) >> 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic [7:0]         r_base;
  logic [15:0]        r_out_data;
  logic               r_overrun;
  logic [7:0]         r_drop_cnt;
  logic [7:0]         w_bank;
  logic               w_accept;
  logic               w_drop;
  logic signed [33:0] w_sum;
  logic signed [33:0] w_shifted;
  logic [15:0]        w_sat;

  // Out-of-range bank selects fall back to bank 0 rather than aliasing.
  assign w_bank   = (band_i < c_NBANDS) ? band_i : 8'd0;
  assign w_accept = (r_state == S_IDLE) && sample_valid_i;
  assign w_drop   = (r_state != S_IDLE) && sample_valid_i;

  assign w_sum     = $signed({mac_result_i[32], mac_result_i}) + $signed(c_ROUND_U);
  assign w_shifted = w_sum >>> SHIFT;
  assign w_sat     = (w_shifted > 34'sd32767)  ? 16'h7FFF :
                     (w_shifted < -34'sd32768) ? 16'h8000 : w_shifted[15:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    win_hold_o  = 1'b1;
    busy_o      = 1'b1;
    coef_addr_o = 8'd0;
    mac_clr_o   = 1'b0;
    mac_en_o    = 1'b0;
    tap_o       = 16'd0;
    tapnum_o    = 8'd0;
    out_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        win_hold_o = 1'b0;
        busy_o     = 1'b0;
        if (sample_valid_i) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_FETCH: begin
        coef_addr_o = r_base;
        mac_clr_o   = 1'b1;
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 8'd0;
      end
      S_RUN: begin
        // ROM data for tap k arrives now; the address for tap k+1 goes out.
        coef_addr_o = r_base + r_cnt + 8'd1;
        mac_en_o    = 1'b1;
        tap_o       = coef_data_i;
        tapnum_o    = r_cnt;
        if (r_cnt == c_LAST_TAP) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = (MAC_LAT == 0) ? S_SCALE : S_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == c_LAST_WAIT) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_SCALE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SCALE: begin
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base     <= 8'd0;
      r_out_data <= 16'd0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_base <= w_bank * c_NTAPS;
      end
      if (r_state == S_SCALE) begin
        r_out_data <= w_sat;
      end
      r_overrun <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_data_o = r_out_data;
  assign overrun_o  = r_overrun;
  assign drop_cnt_o = r_drop_cnt;

endmodule
`default_nettype wire
